// File: rtl/uart_gen2.sv
// uart_gen2: UART with TX/RX FIFOs, optional parity,
// sticky error flags and a registered interrupt.
module uart_gen2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_DIV    = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FADDR_WIDTH = 4,
  parameter int THRESHOLD   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  TX,
  input  logic                  RX,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [FADDR_WIDTH:0]  tx_count,
  output logic [FADDR_WIDTH:0]  rx_count,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  clr_err,
  output logic                  intr
);

  localparam int DEPTH = 2 ** FADDR_WIDTH;
  localparam int CW = $clog2(STOP_BITS * BAUD_DIV + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] C_BIT  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] C_STOP = CW'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [FADDR_WIDTH:0] N_FULL = (FADDR_WIDTH + 1)'(DEPTH);
  localparam logic [FADDR_WIDTH:0] N_THR = (FADDR_WIDTH + 1)'(THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // parity bit that completes the word to the configured sense
  function automatic logic par_bit(input logic [DATA_WIDTH-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0]  r_txf_mem [DEPTH];
  logic [FADDR_WIDTH-1:0] r_txf_wp;
  logic [FADDR_WIDTH-1:0] r_txf_rp;
  logic [FADDR_WIDTH:0]   r_txf_cnt;
  logic                   w_txf_push;
  logic                   w_txf_pop;
  logic                   w_txf_empty;
  logic [DATA_WIDTH-1:0]  w_txf_head;

  assign tx_ready    = (r_txf_cnt != N_FULL);
  assign w_txf_push  = tx_valid & tx_ready;
  assign w_txf_empty = (r_txf_cnt == '0);
  assign w_txf_head  = r_txf_mem[r_txf_rp];
  assign tx_count    = r_txf_cnt;

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (w_txf_push) r_txf_mem[r_txf_wp] <= tx_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txf_wp  <= '0;
      r_txf_rp  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (w_txf_pop)  r_txf_rp <= r_txf_rp + 1'b1;
      case ({w_txf_push, w_txf_pop})
        2'b10:   r_txf_cnt <= r_txf_cnt + 1'b1;
        2'b01:   r_txf_cnt <= r_txf_cnt - 1'b1;
        default: r_txf_cnt <= r_txf_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  state_t                r_tx_st;
  state_t                w_tx_st_nxt;
  logic [CW-1:0]         r_tx_cnt;
  logic [CW-1:0]         w_tx_cnt_nxt;
  logic [BW-1:0]         r_tx_bit;
  logic [BW-1:0]         w_tx_bit_nxt;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] w_tx_sh_nxt;
  logic                  r_tx_par;
  logic                  w_tx_par_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  w_tx_go;

  assign TX      = r_tx;
  assign w_tx_go = enable & ~w_txf_empty;

  // TX state, bit timer and registered line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_tx_st  <= w_tx_st_nxt;
      r_tx_cnt <= w_tx_cnt_nxt;
      r_tx_bit <= w_tx_bit_nxt;
      r_tx_sh  <= w_tx_sh_nxt;
      r_tx_par <= w_tx_par_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  // TX next state; a new frame may start straight out of STOP
  always_comb begin
    w_tx_st_nxt  = r_tx_st;
    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
    w_tx_bit_nxt = r_tx_bit;
    w_tx_sh_nxt  = r_tx_sh;
    w_tx_par_nxt = r_tx_par;
    w_tx_nxt     = r_tx;
    w_txf_pop    = 1'b0;
    unique case (r_tx_st)
      S_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (w_tx_go) begin
          w_txf_pop    = 1'b1;
          w_tx_sh_nxt  = w_txf_head;
          w_tx_par_nxt = par_bit(w_txf_head);
          w_tx_st_nxt  = S_START;
          w_tx_nxt     = 1'b0;
        end
      end
      S_START: begin
        if (r_tx_cnt == C_BIT) begin
          w_tx_cnt_nxt = '0;
          w_tx_bit_nxt = '0;
          w_tx_st_nxt  = S_DATA;
          w_tx_nxt     = r_tx_sh[0];
        end
      end
      S_DATA: begin
        if (r_tx_cnt == C_BIT) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == B_LAST) begin
            if (PARITY != 0) begin
              w_tx_st_nxt = S_PAR;
              w_tx_nxt    = r_tx_par;
            end else begin
              w_tx_st_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_tx_bit_nxt = r_tx_bit + 1'b1;
            w_tx_sh_nxt  = r_tx_sh >> 1;
            w_tx_nxt     = r_tx_sh[1];
          end
        end
      end
      S_PAR: begin
        if (r_tx_cnt == C_BIT) begin
          w_tx_cnt_nxt = '0;
          w_tx_st_nxt  = S_STOP;
          w_tx_nxt     = 1'b1;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == C_STOP) begin
          w_tx_cnt_nxt = '0;
          if (w_tx_go) begin
            w_txf_pop    = 1'b1;
            w_tx_sh_nxt  = w_txf_head;
            w_tx_par_nxt = par_bit(w_txf_head);
            w_tx_st_nxt  = S_START;
            w_tx_nxt     = 1'b0;
          end else begin
            w_tx_st_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_tx_st_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // ---------------- RX sync ----------------
  logic r_rx_s1;
  logic r_rx_s2;
  logic w_rx_s;

  assign w_rx_s = r_rx_s2;

  // two-flop synchronizer for the asynchronous RX pin
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0]  r_rxf_mem [DEPTH];
  logic [FADDR_WIDTH-1:0] r_rxf_wp;
  logic [FADDR_WIDTH-1:0] r_rxf_rp;
  logic [FADDR_WIDTH:0]   r_rxf_cnt;
  logic                   w_rxf_push;
  logic                   w_rxf_pop;
  logic                   w_rxf_full;

  assign w_rxf_full = (r_rxf_cnt == N_FULL);
  assign rx_valid   = (r_rxf_cnt != '0);
  assign w_rxf_pop  = rx_valid & rx_ready;
  assign rx_data    = rx_valid ? r_rxf_mem[r_rxf_rp] : '0;
  assign rx_count   = r_rxf_cnt;

  // ---------------- RX FSM ----------------
  state_t                r_rx_st;
  state_t                w_rx_st_nxt;
  logic [CW-1:0]         r_rx_cnt;
  logic [CW-1:0]         w_rx_cnt_nxt;
  logic [BW-1:0]         r_rx_bit;
  logic [BW-1:0]         w_rx_bit_nxt;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] w_rx_sh_nxt;
  logic                  r_rx_par;
  logic                  w_rx_par_nxt;
  logic                  w_rx_done;
  logic                  w_perr_set;
  logic                  w_ferr_set;
  logic                  w_ovr_set;

  assign w_perr_set = w_rx_done & (PARITY != 0) &
                      (r_rx_par != par_bit(r_rx_sh));
  assign w_ferr_set = w_rx_done & ~w_rx_s;
  assign w_ovr_set  = w_rx_done & w_rxf_full;
  assign w_rxf_push = w_rx_done & ~w_rxf_full;

  // RX FIFO storage write
  always_ff @(posedge clk) begin
    if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= r_rx_sh;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxf_wp  <= '0;
      r_rxf_rp  <= '0;
      r_rxf_cnt <= '0;
    end else begin
      if (w_rxf_push) r_rxf_wp <= r_rxf_wp + 1'b1;
      if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + 1'b1;
      case ({w_rxf_push, w_rxf_pop})
        2'b10:   r_rxf_cnt <= r_rxf_cnt + 1'b1;
        2'b01:   r_rxf_cnt <= r_rxf_cnt - 1'b1;
        default: r_rxf_cnt <= r_rxf_cnt;
      endcase
    end
  end

  // RX state, sample timer and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_par <= 1'b0;
    end else begin
      r_rx_st  <= w_rx_st_nxt;
      r_rx_cnt <= w_rx_cnt_nxt;
      r_rx_bit <= w_rx_bit_nxt;
      r_rx_sh  <= w_rx_sh_nxt;
      r_rx_par <= w_rx_par_nxt;
    end
  end

  // RX next state; samples at mid-bit, first stop bit only
  always_comb begin
    w_rx_st_nxt  = r_rx_st;
    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
    w_rx_bit_nxt = r_rx_bit;
    w_rx_sh_nxt  = r_rx_sh;
    w_rx_par_nxt = r_rx_par;
    w_rx_done    = 1'b0;
    unique case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (enable & ~w_rx_s) w_rx_st_nxt = S_START;
      end
      S_START: begin
        if (r_rx_cnt == C_HALF) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = '0;
          w_rx_st_nxt  = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == C_BIT) begin
          w_rx_cnt_nxt = '0;
          w_rx_sh_nxt  = {w_rx_s, r_rx_sh[DATA_WIDTH-1:1]};
          if (r_rx_bit == B_LAST) begin
            w_rx_st_nxt = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (r_rx_cnt == C_BIT) begin
          w_rx_cnt_nxt = '0;
          w_rx_par_nxt = w_rx_s;
          w_rx_st_nxt  = S_STOP;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == C_BIT) begin
          w_rx_cnt_nxt = '0;
          w_rx_done    = 1'b1;
          w_rx_st_nxt  = S_IDLE;
        end
      end
      default: w_rx_st_nxt = S_IDLE;
    endcase
  end

  // ---------------- flags / intr ----------------
  logic r_perr;
  logic r_ferr;
  logic r_ovr;
  logic r_intr;

  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign intr       = r_intr;

  // sticky flags; a new error beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_perr <= w_perr_set | (r_perr & ~clr_err);
      r_ferr <= w_ferr_set | (r_ferr & ~clr_err);
      r_ovr  <= w_ovr_set  | (r_ovr  & ~clr_err);
    end
  end

  // interrupt registered from fill level and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= (r_rxf_cnt >= N_THR) | r_perr | r_ferr | r_ovr;
    end
  end

endmodule

// File: doc/uart_gen2.md
UART_GEN2 -- requirements
Module: uart_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per frame, legal range 5..9.
REQ-002 SHALL have parameter BAUD_DIV, default 16: clk cycles per bit, minimum 4.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: 1 or 2.
REQ-005 SHALL have parameter FADDR_WIDTH, default 4: each FIFO depth = 2**FADDR_WIDTH.
REQ-006 SHALL have parameter THRESHOLD, default 3: RX fill level that raises intr.
REQ-007 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  UART enable.
- TX  out  1  serial output; idle high.
- RX  in  1  serial input; asynchronous.
- tx_data  in  DATA_WIDTH  TX FIFO write data.
- tx_valid  in  1  TX write request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_WIDTH  RX FIFO head; first-word fall-through.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  RX pop request.
- tx_count  out  FADDR_WIDTH+1  TX FIFO occupancy.
- rx_count  out  FADDR_WIDTH+1  RX FIFO occupancy.
- parity_err  out  1  sticky flag.
- frame_err  out  1  sticky flag.
- overrun  out  1  sticky flag.
- clr_err  in  1  one-cycle pulse clearing the sticky flags.
- intr  out  1  registered interrupt.

Function
REQ-008 SHALL write tx_data into the TX FIFO on the clk edge where tx_valid & tx_ready; tx_ready SHALL be !full, with no bypass when full and a pop occur in the same cycle.
REQ-009 SHALL pop the RX FIFO on the edge where rx_valid & rx_ready; rx_ready while rx_valid=0 SHALL be ignored.
REQ-010 SHALL wrap FIFO pointers modulo depth; occupancy SHALL be 0..depth; a simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the count unchanged.
REQ-011 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-012 In IDLE with enable=1 and TX FIFO non-empty, the TX FSM SHALL pop one word and enter START; TX SHALL go low on the second edge after a push into an empty FIFO.
REQ-013 Each TX bit SHALL be held exactly BAUD_DIV cycles; data SHALL be sent LSB first.
REQ-014 The parity bit SHALL make the total count of ones odd (PARITY=1) or even (PARITY=2); STOP SHALL drive 1 for STOP_BITS*BAUD_DIV cycles.
REQ-015 After STOP, the TX FSM SHALL return to IDLE and SHALL allow back-to-back frames with no idle gap.
REQ-016 enable deasserted mid-frame SHALL let the current TX frame complete, then hold TX high.
REQ-017 RX SHALL pass through a 2-flop synchronizer before any use.
REQ-018 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 The RX FSM SHALL leave IDLE on a synchronized low while enable=1.
REQ-020 The RX FSM SHALL resample at BAUD_DIV/2 cycles; if the line is high, it SHALL return to IDLE (glitch rejection).
REQ-021 Subsequent RX samples SHALL be taken every BAUD_DIV cycles at mid-bit.
REQ-022 Only the first stop bit SHALL be checked.
REQ-023 At the stop-bit sample, the received word SHALL be written to the RX FIFO, and rx_valid SHALL rise on the next edge.
REQ-024 A parity mismatch SHALL set parity_err and a stop sample of 0 SHALL set frame_err; the word SHALL still be stored.
REQ-025 A frame completing while the RX FIFO is full SHALL be discarded, SHALL set overrun, and SHALL leave the FIFO contents unchanged.
REQ-026 clr_err SHALL clear all three flags; a new error in the same cycle SHALL win, leaving that flag set.
REQ-027 intr SHALL be registered, equal to (rx_count >= THRESHOLD) | parity_err | frame_err | overrun, one cycle after the cause.

Reset
REQ-028 On a clk edge with reset=1: TX=1; tx_ready=1; rx_valid=0; counts=0; flags=0; intr=0; both FSMs in IDLE; rx_data=0.
REQ-029 Reset mid-frame SHALL abort the frame and discard all FIFO contents.
REQ-030 No state SHALL change on reset alone without a clk edge.

Verification (DATA_WIDTH=8, BAUD_DIV=4, PARITY=2, STOP_BITS=1, FADDR_WIDTH=2)
REQ-031 Push 0xA5 with enable=1 -> TX low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, parity 0, stop 1; frame = 44 cycles.
REQ-032 TX looped to RX, push 0x3C -> rx_data=0x3C, rx_valid=1, rx_count=1, all flags 0, intr 0.
REQ-033 Drive an RX frame 0x01 with parity 0 -> parity_err=1, intr=1 next cycle, word 0x01 stored; clr_err pulse -> parity_err=0.
REQ-034 Send 5 frames with rx_ready=0 -> rx_count=4, overrun=1, FIFO holds frames 1..4; intr asserted once rx_count reaches 3.
REQ-035 Drive RX low for 1 cycle only -> no frame, rx_count=0, no flags set.
REQ-036 Assert reset during the DATA bits of a TX frame with 2 words queued -> TX=1 next cycle, tx_count=0, no further frame sent.
